// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word accesses to a word-wide data memory with
// sign/zero extension, read-modify-write for sub-word stores, and alignment/range errors.
module load_store_unit #(
  parameter int unsigned ADDR_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StErr} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;

  logic        accept;
  logic        req_err;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_ext;
  logic [31:0] store_word;

  assign accept = req_valid && (state_q == StIdle);

  // Illegal size, misalignment, or any address bit at/above ADDR_BITS.
  assign req_err = (req_size == 2'b11)
                || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                || ((req_size == 2'b01) && req_addr[0])
                || (|(req_addr >> ADDR_BITS));

  assign byte_lane = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
  assign half_lane = mem_rdata[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = mem_rdata;
    unique case (size_q)
      2'b00:   load_ext = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
      2'b01:   load_ext = {{16{~unsigned_q & half_lane[15]}}, half_lane};
      default: load_ext = mem_rdata;
    endcase
  end

  always_comb begin
    store_word = merge_q;
    unique case (size_q)
      2'b00:   store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: store_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          if (req_err)                 state_d = StErr;
          else if (!req_write)         state_d = StLoad;
          else if (req_size == 2'b10)  state_d = StWrite;
          else                         state_d = StRmwRd;
        end
      end
      StRmwRd: begin
        merge_d = mem_rdata;
        state_d = StWrite;
      end
      StLoad, StWrite, StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response registers fire on leaving a final state, so the pulse lands in IDLE.
  always_comb begin
    resp_valid_d = (state_q == StLoad) || (state_q == StWrite) || (state_q == StErr);
    resp_err_d   = (state_q == StErr);
    resp_rdata_d = (state_q == StLoad) ? load_ext : 32'h0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      merge_q      <= merge_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = resp_valid_q;
    resp_err   = resp_err_q;
    resp_rdata = resp_rdata_q;
    mem_write  = (state_q == StWrite);
    mem_wdata  = (state_q == StWrite) ? store_word : 32'h0;
    if (!rst) begin
      mem_addr = 32'h0;
    end else if (state_q == StIdle) begin
      mem_addr = {req_addr[31:2], 2'b00};
    end else begin
      mem_addr = {addr_q[31:2], 2'b00};
    end
  end

  // write_q is kept for completeness of the latched request; the FSM already encodes it.
  logic unused_write;
  assign unused_write = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized checks of load_store_unit against a byte-level reference model.
module tb_load_store_unit;
  localparam int unsigned AddrBits = 16;
  localparam int unsigned MemWords = 16384;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_BITS(AddrBits)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Bench-side data memory with a backdoor port for preloading.
  logic [31:0] mem [MemWords];
  logic [31:0] ref_mem [MemWords];
  logic        bd_we = 1'b0;
  logic [13:0] bd_idx = '0;
  logic [31:0] bd_data = '0;
  int unsigned wr_cnt = 0;

  assign mem_rdata = mem[mem_addr[15:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      mem[mem_addr[15:2]] <= mem_wdata;
      wr_cnt++;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx[13:0]; bd_data = data;
    @(posedge clk);
    #1 bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  // Reference: byte-addressed arithmetic on ref_mem.
  task automatic model(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd,
                       output int lat, output int nwr);
    int nb;
    int idx;
    int sh;
    logic [31:0] mask;
    logic [31:0] v;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((a % nb) != 0) || (64'(a) >= (64'd1 << AddrBits));
    rd  = 32'h0; lat = 2; nwr = 0;
    if (err) return;
    idx  = int'(a / 4);
    sh   = int'(a % 4) * 8;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
    if (!wr) begin
      v = (ref_mem[idx] >> sh) & mask;
      if (!uns && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
      rd = v;
    end else begin
      ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wd & mask) << sh);
      nwr = 1;
      lat = (nb == 4) ? 2 : 3;
    end
  endtask

  task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] obs_rd,
                        output logic obs_err);
    bit          e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_nwr;
    int          cyc;
    int unsigned w0;
    model(wr, sz, uns, a, wd, e_err, e_rd, e_lat, e_nwr);
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    #1;
    chk("ready", {31'b0, req_ready}, 32'd1);
    chk("idle_addr", mem_addr, {a[31:2], 2'b00});
    chk("idle_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    w0 = wr_cnt;
    #1 req_valid = 1'b0;
    cyc = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        cyc = c;
        break;
      end
    end
    chk("latency", cyc, e_lat);
    chk("err", {31'b0, resp_err}, {31'b0, e_err});
    chk("rdata", resp_rdata, e_rd);
    chk("writes", wr_cnt - w0, e_nwr);
    if (wr && !e_err) chk("mem_word", mem[a[15:2]], ref_mem[a[15:2]]);
    obs_rd  = resp_rdata;
    obs_err = resp_err;
    @(negedge clk);
    chk("pulse", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] wd;
    logic [31:0] a;
    logic [1:0]  sz;
    int          nvalid;
    bit          e_err;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_nwr;

    // Reset state
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_err", {31'b0, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mwrite", {31'b0, mem_write}, 32'd0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 64; i++) poke(i, $urandom);
    poke(32'h40 / 4, 32'h8899_AABB);

    do_req(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, rd, er);
    chk("byte_signed", rd, 32'hFFFF_FFAA);
    do_req(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, rd, er);
    chk("half_unsigned", rd, 32'h0000_8899);
    do_req(1'b1, 2'b00, 1'b0, 32'h43, 32'h11, rd, er);
    chk("byte_store", mem[32'h40 / 4], 32'h1199_AABB);
    do_req(1'b0, 2'b10, 1'b0, 32'h46, 32'h0, rd, er);
    chk("misaligned_word", {31'b0, er}, 32'd1);
    do_req(1'b1, 2'b01, 1'b0, 32'h45, 32'hBEEF, rd, er);
    chk("misaligned_half", {31'b0, er}, 32'd1);
    do_req(1'b0, 2'b00, 1'b1, 32'h0001_0000, 32'h0, rd, er);
    chk("out_of_range", {31'b0, er}, 32'd1);
    do_req(1'b0, 2'b11, 1'b0, 32'h8, 32'h0, rd, er);
    chk("illegal_size", {31'b0, er}, 32'd1);

    // Back-to-back word store then load with req_valid held.
    wd = 32'hC0DE_1234;
    model(1'b1, 2'b10, 1'b0, 32'h10, wd, e_err, e_rd, e_lat, e_nwr);
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_write = 1'b0; req_wdata = 32'h0;
    @(negedge clk);
    chk("b2b_busy", {31'b0, req_ready}, 32'd0);
    chk("b2b_mwrite", {31'b0, mem_write}, 32'd1);
    @(negedge clk);
    chk("b2b_resp", {31'b0, resp_valid}, 32'd1);
    chk("b2b_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_gap", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    chk("b2b_load_valid", {31'b0, resp_valid}, 32'd1);
    chk("b2b_load_data", resp_rdata, wd);

    // Reset pulsed during WRITE of a byte store.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b00; req_addr = 32'h21; req_wdata = 32'h5A;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_write", {31'b0, mem_write}, 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_mwrite", {31'b0, mem_write}, 32'd0);
    chk("abort_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_maddr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_valid) nvalid++;
    end
    chk("abort_noresp", nvalid, 32'd0);
    chk("abort_mem", mem[32'h20 / 4], ref_mem[32'h20 / 4]);
    chk("abort_idle", {31'b0, req_ready}, 32'd1);

    // Randomized traffic, mostly within the preloaded window.
    for (int i = 0; i < 80; i++) begin
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, rd, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ADDR_BITS, default 16, number of low request-address bits forwarded to data memory.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: req_valid  input  1  CPU presents an access this cycle.
REQ-005 Port: req_ready  output  1  unit accepts a request this cycle; high only in state IDLE.
REQ-006 Port: req_write  input  1  1 = store, 0 = load.
REQ-007 Port: req_size  input  2  00 = byte, 01 = halfword, 10 = word; 11 is illegal.
REQ-008 Port: req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-009 Port: req_addr  input  32  signed byte address from the ALU.
REQ-010 Port: req_wdata  input  32  store data, right-aligned.
REQ-011 Port: resp_valid  output  1  one-cycle pulse marking completion of the accepted request.
REQ-012 Port: resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores and errors.
REQ-013 Port: resp_err  output  1  request was misaligned, out of range or illegal; valid with resp_valid.
REQ-014 Port: mem_addr  output  32  word-aligned byte address to data memory, {addr[31:2],2'b00}.
REQ-015 Port: mem_wdata  output  32  full word written to data memory.
REQ-016 Port: mem_write  output  1  data-memory write enable; memory writes on the next rising edge.
REQ-017 Port: mem_rdata  input  32  combinational read of the word at mem_addr.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, RMW_RD, WRITE and ERR.
REQ-019 Accept SHALL occur when req_valid and req_ready are both high at a rising edge; all req_* fields are latched at accept.
REQ-020 Error check at accept: word with addr[1:0]!=0, halfword with addr[0]=1, req_size=11, or any req_addr bit at or above ADDR_BITS set SHALL go to ERR.
REQ-021 Legal access at accept: a load SHALL go to LOAD, a word store to WRITE, and a byte or halfword store to RMW_RD.
REQ-022 LOAD: drive mem_addr, keep mem_write=0, extract the lane from mem_rdata, extend it, register it into resp_rdata, pulse resp_valid next cycle and return to IDLE.
REQ-023 Lanes are little-endian: byte k = bits [8k+7:8k] with k = addr[1:0]; halfword h = bits [16h+15:16h] with h = addr[1].
REQ-024 RMW_RD: capture mem_rdata into the merge register and go to WRITE; memory is not written in this state.
REQ-025 WRITE: mem_write=1 for exactly one cycle; mem_wdata = merge word with only the addressed lane replaced by the low bits of req_wdata (whole req_wdata for a word store); pulse resp_valid next cycle and return to IDLE.
REQ-026 ERR: no memory access; pulse resp_valid with resp_err=1 and resp_rdata=0 next cycle and return to IDLE.
REQ-027 Latency from accept edge to resp_valid high: load 2 cycles, word store 2, sub-word store 3, error 2.
REQ-028 resp_valid SHALL be high only in the cycle after the final state, which is an IDLE cycle, so a new request can be accepted in the same cycle as a response.
REQ-029 mem_write SHALL be decoded from state WRITE only and never be high in any other state.
REQ-030 In IDLE, mem_addr SHALL follow the word-aligned req_addr and mem_wdata SHALL be 0.

Reset
REQ-031 While rst=0: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_write=0, mem_addr=0 and mem_wdata=0, asynchronously.
REQ-032 Reset asserted in any state, including WRITE, SHALL drop mem_write immediately, and no response SHALL be issued for the aborted request.

Verification
REQ-033 Memory word 0x40 = 0x8899AABB, load byte signed at 0x41 -> resp_rdata=0xFFFFFFAA, resp_err=0, resp_valid 2 cycles after accept.
REQ-034 Same word, load halfword unsigned at 0x42 -> resp_rdata=0x00008899.
REQ-035 Store byte 0x11 at 0x43 -> memory word 0x40 = 0x1199AABB, mem_write high for exactly 1 cycle, resp_valid 3 cycles after accept.
REQ-036 Word load at 0x46 and halfword store at 0x45 -> resp_err=1, resp_rdata=0, mem_write never high.
REQ-037 Back-to-back word store to 0x10 then load from 0x10 with req_valid held -> second accept on the response cycle, load returns the stored value.
REQ-038 rst pulsed low during WRITE of a byte store -> mem_write falls with rst, no resp_valid, unit returns to IDLE with req_ready=1.
